alu: RTL and testbench



---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_datapath.sv | 45 ++++
 rtl/alu.sv | 31 +++
 tb/tb_alu.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU: data width and the 4-bit opcode map.
// Imported by the RTL and by the testbench.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
    localparam logic [OP_W-1:0] OP_MUL  = 4'b0010;
    localparam logic [OP_W-1:0] OP_DIV  = 4'b0011;
    localparam logic [OP_W-1:0] OP_MOD  = 4'b0100;
    localparam logic [OP_W-1:0] OP_SHL  = 4'b0101;
    localparam logic [OP_W-1:0] OP_LTH  = 4'b0110;
    localparam logic [OP_W-1:0] OP_EQ   = 4'b0111;
    localparam logic [OP_W-1:0] OP_GTH  = 4'b1000;
    localparam logic [OP_W-1:0] OP_AND  = 4'b1001;
    localparam logic [OP_W-1:0] OP_OR   = 4'b1010;
    localparam logic [OP_W-1:0] OP_XOR  = 4'b1011;
    localparam logic [OP_W-1:0] OP_NAND = 4'b1100;
    localparam logic [OP_W-1:0] OP_SHR  = 4'b1101;
    localparam logic [OP_W-1:0] OP_NOT  = 4'b1110;
    localparam logic [OP_W-1:0] OP_PASS = 4'b1111;

    // Compare outcomes live in bit 0 only.
    function automatic logic [DATA_W-1:0] flag_word(input logic flag);
        return {{(DATA_W-1){1'b0}}, flag};
    endfunction

endpackage

// File: rtl/alu_datapath.sv
// Purely combinational ALU core: computes the next result from A, B and opcode.
// Divide/modulo by zero are mapped to fixed values so no X ever escapes.
module alu_datapath
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [OP_W-1:0]   opcode,
    output logic [DATA_W-1:0] result
);

    logic [2:0]        shamt;
    logic              b_zero;
    logic [DATA_W-1:0] quot;
    logic [DATA_W-1:0] rem;

    assign shamt  = B[2:0];
    assign b_zero = (B == '0);
    assign quot   = b_zero ? '1 : (A / B);
    assign rem    = b_zero ? A  : (A % B);

    always_comb begin
        result = '0;
        case (opcode)
            OP_ADD:  result = A + B;
            OP_SUB:  result = A - B;
            OP_MUL:  result = A * B;
            OP_DIV:  result = quot;
            OP_MOD:  result = rem;
            OP_SHL:  result = A << shamt;
            OP_LTH:  result = flag_word(A < B);
            OP_EQ:   result = flag_word(A == B);
            OP_GTH:  result = flag_word(A > B);
            OP_AND:  result = A & B;
            OP_OR:   result = A | B;
            OP_XOR:  result = A ^ B;
            OP_NAND: result = ~(A & B);
            OP_SHR:  result = A >> shamt;
            OP_NOT:  result = ~A;
            OP_PASS: result = A;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// 8-bit unsigned ALU with a single registered output; one-cycle latency.
// Reset clears the output asynchronously and discards any pending result.
module alu
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [OP_W-1:0]   opcode,
    output logic [DATA_W-1:0] ALU_Out
);

    logic [DATA_W-1:0] next_result;

    alu_datapath u_datapath (
        .A      (A),
        .B      (B),
        .opcode (opcode),
        .result (next_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALU_Out <= '0;
        end else begin
            ALU_Out <= next_result;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed testbench for alu: hand-computed vectors, reset/hold timing,
// and a full opcode sweep against an independent reference model.
module tb_alu;
    import alu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] opcode;
    logic [7:0] ALU_Out;

    int tests_run;
    int tests_failed;

    alu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (A),
        .B       (B),
        .opcode  (opcode),
        .ALU_Out (ALU_Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Drive inputs away from the edge, then sample just after the loading edge.
    task automatic apply(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        opcode = op;
        A      = a;
        B      = b;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input string tag, input logic [3:0] op,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp);
        apply(op, a, b);
        check(tag, ALU_Out, exp);
    endtask

    // Reference written with wide integer arithmetic and explicit masking.
    function automatic logic [7:0] ref_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int unsigned ia;
        int unsigned ib;
        int unsigned r;
        ia = a;
        ib = b;
        case (op)
            4'd0:  r = (ia + ib) % 256;
            4'd1:  r = (ia + 256 - ib) % 256;
            4'd2:  r = (ia * ib) % 256;
            4'd3:  r = (ib == 0) ? 255 : ia / ib;
            4'd4:  r = (ib == 0) ? ia : ia % ib;
            4'd5:  r = (ia * (1 << (ib % 8))) % 256;
            4'd6:  r = (ia < ib) ? 1 : 0;
            4'd7:  r = (ia == ib) ? 1 : 0;
            4'd8:  r = (ia > ib) ? 1 : 0;
            4'd9:  r = ia & ib;
            4'd10: r = ia | ib;
            4'd11: r = ia ^ ib;
            4'd12: r = 255 - (ia & ib);
            4'd13: r = ia / (1 << (ib % 8));
            4'd14: r = 255 - ia;
            default: r = ia;
        endcase
        return r[7:0];
    endfunction

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n  = 1'b0;
        A      = '0;
        B      = '0;
        opcode = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", ALU_Out, 8'h00);

        @(negedge clk);
        rst_n = 1'b1;
        run_vec("pass_37", OP_PASS, 8'h37, 8'h00, 8'h37);

        // Asynchronous reset mid-cycle, before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", ALU_Out, 8'h00);
        @(posedge clk);
        #1;
        check("reset_held", ALU_Out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("lth_after_reset", OP_LTH, 8'd1, 8'd2, 8'h01);

        run_vec("lth_1_1",  OP_LTH, 8'd1,  8'd1,  8'h00);
        run_vec("lth_10_5", OP_LTH, 8'd10, 8'd5,  8'h00);
        run_vec("lth_2_25", OP_LTH, 8'd2,  8'd25, 8'h01);
        run_vec("lth_2_2",  OP_LTH, 8'd2,  8'd2,  8'h00);

        run_vec("add_wrap", OP_ADD, 8'd200, 8'd100, 8'h2C);
        run_vec("sub_wrap", OP_SUB, 8'd5,   8'd10,  8'hFB);
        run_vec("mul_wrap", OP_MUL, 8'd20,  8'd20,  8'h90);

        run_vec("div_100_7", OP_DIV, 8'd100, 8'd7, 8'h0E);
        run_vec("div_by_0",  OP_DIV, 8'd9,   8'd0, 8'hFF);
        run_vec("mod_100_7", OP_MOD, 8'd100, 8'd7, 8'h02);
        run_vec("mod_by_0",  OP_MOD, 8'd9,   8'd0, 8'h09);

        run_vec("and",  OP_AND,  8'hF0, 8'h3C, 8'h30);
        run_vec("or",   OP_OR,   8'hF0, 8'h3C, 8'hFC);
        run_vec("xor",  OP_XOR,  8'hF0, 8'h3C, 8'hCC);
        run_vec("nand", OP_NAND, 8'hF0, 8'h3C, 8'hCF);
        run_vec("not",  OP_NOT,  8'hF0, 8'h3C, 8'h0F);
        run_vec("shl",  OP_SHL,  8'hF0, 8'h0B, 8'h80);
        run_vec("shr",  OP_SHR,  8'hF0, 8'h04, 8'h0F);
        run_vec("eq",   OP_EQ,   8'h5A, 8'h5A, 8'h01);
        run_vec("gth",  OP_GTH,  8'h81, 8'h80, 8'h01);
        run_vec("shr7", OP_SHR,  8'h80, 8'hFF, 8'h01);

        // Hold: input changes between edges must not disturb the output.
        run_vec("hold_base", OP_ADD, 8'd3, 8'd4, 8'h07);
        @(negedge clk);
        opcode = OP_MUL;
        A      = 8'd6;
        B      = 8'd7;
        #2;
        check("hold_between_edges", ALU_Out, 8'h07);
        @(posedge clk);
        #1;
        check("hold_next_edge", ALU_Out, 8'h2A);

        // Back-to-back sweep, one opcode per cycle.
        for (int pass = 0; pass < 3; pass++) begin
            for (int op = 0; op < 16; op++) begin
                logic [7:0] ra;
                logic [7:0] rb;
                ra = 8'($urandom_range(0, 255));
                rb = (pass == 0) ? 8'h00 : 8'($urandom_range(0, 255));
                apply(4'(op), ra, rb);
                check($sformatf("sweep_op%0d_%02h_%02h", op, ra, rb),
                      ALU_Out, ref_model(4'(op), ra, rb));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
